// File: rtl/pipeline_controller_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding
// and the bundle of per-register stall/flush controls.
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_ERROR    = 2'd2
  } ctrl_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_stall;
    logic if_flush;
    logic id_stall;
    logic id_flush;
    logic ex_stall;
    logic mem_stall;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  localparam ctrl_t CTRL_STALL_ALL = '{
    pc_stall: 1'b1, if_stall: 1'b1, if_flush: 1'b0, id_stall: 1'b1,
    id_flush: 1'b0, ex_stall: 1'b1, mem_stall: 1'b1
  };

  // Wrong-path fetch and decode are squashed; nothing is held.
  localparam ctrl_t CTRL_REDIRECT = '{
    pc_stall: 1'b0, if_stall: 1'b0, if_flush: 1'b1, id_stall: 1'b0,
    id_flush: 1'b1, ex_stall: 1'b0, mem_stall: 1'b0
  };

  // Hold fetch/decode one cycle and push a bubble into EX.
  localparam ctrl_t CTRL_LOAD_USE = '{
    pc_stall: 1'b1, if_stall: 1'b1, if_flush: 1'b0, id_stall: 1'b0,
    id_flush: 1'b1, ex_stall: 1'b0, mem_stall: 1'b0
  };

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard inputs from the datapath and stall/flush/status outputs of the
// pipeline controller. The controller side uses the master modport.
interface pipeline_controller_if #(parameter int CNT_W = 32);

  logic [4:0]       id_rs1_i;
  logic [4:0]       id_rs2_i;
  logic [4:0]       ex_rd_i;
  logic             ex_read_mem_i;
  logic             ex_branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ready_i;

  logic             pc_stall_o;
  logic             if_stall_o;
  logic             if_flush_o;
  logic             id_stall_o;
  logic             id_flush_o;
  logic             ex_stall_o;
  logic             mem_stall_o;
  logic             error_o;
  logic [CNT_W-1:0] stall_cycles_o;
  logic [CNT_W-1:0] flush_count_o;

  modport master (
    input  id_rs1_i, id_rs2_i, ex_rd_i, ex_read_mem_i, ex_branch_taken_i,
           dmem_req_i, dmem_ready_i,
    output pc_stall_o, if_stall_o, if_flush_o, id_stall_o, id_flush_o,
           ex_stall_o, mem_stall_o, error_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    output id_rs1_i, id_rs2_i, ex_rd_i, ex_read_mem_i, ex_branch_taken_i,
           dmem_req_i, dmem_ready_i,
    input  pc_stall_o, if_stall_o, if_flush_o, id_stall_o, id_flush_o,
           ex_stall_o, mem_stall_o, error_o, stall_cycles_o, flush_count_o
  );

endinterface

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. Register x0 is hardwired and never creates a hazard.
module hazard_detect (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  input  logic       read_mem,
  output logic       load_use
);

  assign load_use = read_mem && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait beats branch
// redirect beats load-use, with a memory-wait watchdog and perf counters.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  pipeline_controller_if.master   bus
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_e      state, next_state;
  logic [WD_W-1:0]  watchdog, next_watchdog;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  ctrl_t            ctrl;
  logic             redirect;
  logic             error;
  logic             load_use;
  logic             mem_wait;

  hazard_detect u_hazard_detect (
    .rs1      (bus.id_rs1_i),
    .rs2      (bus.id_rs2_i),
    .rd       (bus.ex_rd_i),
    .read_mem (bus.ex_read_mem_i),
    .load_use (load_use)
  );

  assign mem_wait = bus.dmem_req_i && !bus.dmem_ready_i;

  // Controls are zero-latency from state and inputs, and forced off in reset.
  always_comb begin
    next_state    = state;
    next_watchdog = watchdog;
    ctrl          = CTRL_NONE;
    redirect      = 1'b0;
    error         = 1'b0;
    if (!reset) begin
      case (state)
        CTRL_RUN: begin
          if (mem_wait) begin
            ctrl          = CTRL_STALL_ALL;
            next_state    = CTRL_MEM_WAIT;
            next_watchdog = WD_W'(1);
          end else if (bus.ex_branch_taken_i) begin
            ctrl     = CTRL_REDIRECT;
            redirect = 1'b1;
          end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
          end
        end
        CTRL_MEM_WAIT: begin
          // EX is frozen here, so a held branch is acted on only back in RUN.
          if (bus.dmem_ready_i) begin
            next_state    = CTRL_RUN;
            next_watchdog = '0;
          end else begin
            ctrl          = CTRL_STALL_ALL;
            next_watchdog = watchdog + WD_W'(1);
            if (watchdog == WD_W'(MEM_TIMEOUT - 1)) begin
              next_state = CTRL_ERROR;
            end
          end
        end
        CTRL_ERROR: begin
          ctrl  = CTRL_STALL_ALL;
          error = 1'b1;
        end
        default: begin
          ctrl       = CTRL_STALL_ALL;
          next_state = CTRL_ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CTRL_RUN;
      watchdog     <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state    <= next_state;
      watchdog <= next_watchdog;
      if (ctrl.pc_stall) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (redirect) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

  assign bus.pc_stall_o     = ctrl.pc_stall;
  assign bus.if_stall_o     = ctrl.if_stall;
  assign bus.if_flush_o     = ctrl.if_flush;
  assign bus.id_stall_o     = ctrl.id_stall;
  assign bus.id_flush_o     = ctrl.id_flush;
  assign bus.ex_stall_o     = ctrl.ex_stall;
  assign bus.mem_stall_o    = ctrl.mem_stall;
  assign bus.error_o        = error;
  assign bus.stall_cycles_o = stall_cycles;
  assign bus.flush_count_o  = flush_count;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_controller;

  localparam int TIMEOUT = 4;
  localparam int CW      = 4;
  localparam int CMOD    = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_controller_if #(.CNT_W(CW)) bus ();

  pipeline_controller #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int nChecks  = 0;
  int nErrors  = 0;
  bit modelLive = 1'b0;

  // Model state: waiting on memory, failed on timeout, length of current wait.
  bit mWaiting = 1'b0;
  bit mFailed  = 1'b0;
  int mWaitLen = 0;
  int mStalls  = 0;
  int mFlushes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [4:0] rd,
                               input logic rm, input logic br,
                               input logic req, input logic rdy);
    @(posedge clk);
    #1;
    reset                 = rst;
    bus.id_rs1_i          = rs1;
    bus.id_rs2_i          = rs2;
    bus.ex_rd_i           = rd;
    bus.ex_read_mem_i     = rm;
    bus.ex_branch_taken_i = br;
    bus.dmem_req_i        = req;
    bus.dmem_ready_i      = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] dutCtrl();
    return {bus.pc_stall_o, bus.if_stall_o, bus.if_flush_o, bus.id_stall_o,
            bus.id_flush_o, bus.ex_stall_o, bus.mem_stall_o, bus.error_o};
  endfunction

  // Reference: expected controls this cycle, then advance to the next cycle.
  always @(negedge clk) begin
    bit hazard, waitNow, freeze, redirect, bubble, failed;
    logic [7:0] expCtrl;
    if (modelLive) begin
      hazard  = bus.ex_read_mem_i && bus.ex_rd_i != 0 &&
                (bus.ex_rd_i == bus.id_rs1_i || bus.ex_rd_i == bus.id_rs2_i);
      waitNow = bus.dmem_req_i && !bus.dmem_ready_i;
      freeze = 0; redirect = 0; bubble = 0; failed = 0;
      if (!reset) begin
        if (mFailed) begin
          freeze = 1; failed = 1;
        end else if (mWaiting) begin
          freeze = !bus.dmem_ready_i;
        end else if (waitNow) begin
          freeze = 1;
        end else if (bus.ex_branch_taken_i) begin
          redirect = 1;
        end else if (hazard) begin
          bubble = 1;
        end
      end
      expCtrl = {freeze | bubble, freeze | bubble, redirect, freeze,
                 redirect | bubble, freeze, freeze, failed};
      checkOutput("ctrl", 32'(dutCtrl()), 32'(expCtrl));
      checkOutput("stall_cycles", 32'(bus.stall_cycles_o), 32'(mStalls));
      checkOutput("flush_count", 32'(bus.flush_count_o), 32'(mFlushes));

      if (reset) begin
        mWaiting = 0; mFailed = 0; mWaitLen = 0; mStalls = 0; mFlushes = 0;
      end else begin
        if (freeze || bubble) mStalls = (mStalls + 1) % CMOD;
        if (redirect) mFlushes = (mFlushes + 1) % CMOD;
        if (!mFailed) begin
          if (mWaiting) begin
            if (bus.dmem_ready_i) begin
              mWaiting = 0; mWaitLen = 0;
            end else begin
              mWaitLen++;
              if (mWaitLen >= TIMEOUT) begin
                mFailed = 1; mWaiting = 0;
              end
            end
          end else if (waitNow) begin
            mWaiting = 1; mWaitLen = 1;
          end
        end
      end
    end
  end

  initial begin
    reset                 = 1'b1;
    bus.id_rs1_i          = '0;
    bus.id_rs2_i          = '0;
    bus.ex_rd_i           = '0;
    bus.ex_read_mem_i     = 1'b0;
    bus.ex_branch_taken_i = 1'b0;
    bus.dmem_req_i        = 1'b0;
    bus.dmem_ready_i      = 1'b0;
    doReset();
    doReset();
    modelLive = 1'b1;

    // Load-use, then the same with x0 as destination.
    doReset();
    applyStimulus(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_pc_stall", 32'(bus.pc_stall_o), 32'd1);
    checkOutput("lu_if_stall", 32'(bus.if_stall_o), 32'd1);
    checkOutput("lu_id_flush", 32'(bus.id_flush_o), 32'd1);
    checkOutput("lu_id_stall", 32'(bus.id_stall_o), 32'd0);
    idle();
    checkOutput("lu_stall_cycles", 32'(bus.stall_cycles_o), 32'd1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("lu_x0_pc_stall", 32'(bus.pc_stall_o), 32'd0);
    checkOutput("lu_x0_id_flush", 32'(bus.id_flush_o), 32'd0);

    // Branch overrides a simultaneous load-use.
    doReset();
    applyStimulus(1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("br_if_flush", 32'(bus.if_flush_o), 32'd1);
    checkOutput("br_id_flush", 32'(bus.id_flush_o), 32'd1);
    checkOutput("br_pc_stall", 32'(bus.pc_stall_o), 32'd0);
    idle();
    checkOutput("br_flush_count", 32'(bus.flush_count_o), 32'd1);

    // Three-cycle memory wait, then ready.
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("mw_pc_stall", 32'(bus.pc_stall_o), 32'd1);
      checkOutput("mw_mem_stall", 32'(bus.mem_stall_o), 32'd1);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mw_ready_ex_stall", 32'(bus.ex_stall_o), 32'd0);
    idle();
    checkOutput("mw_stall_cycles", 32'(bus.stall_cycles_o), 32'd3);

    // Held branch during a two-cycle wait acts only once back in RUN.
    doReset();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bw_if_flush_0", 32'(bus.if_flush_o), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bw_if_flush_1", 32'(bus.if_flush_o), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("bw_ready_id_flush", 32'(bus.id_flush_o), 32'd0);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("bw_run_if_flush", 32'(bus.if_flush_o), 32'd1);
    idle();
    checkOutput("bw_flush_count", 32'(bus.flush_count_o), 32'd1);

    // Watchdog timeout, then reset recovery.
    doReset();
    for (int i = 0; i < TIMEOUT; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("to_error_early", 32'(bus.error_o), 32'd0);
    end
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("to_error", 32'(bus.error_o), 32'd1);
    checkOutput("to_mem_stall", 32'(bus.mem_stall_o), 32'd1);
    doReset();
    checkOutput("to_rst_pc_stall", 32'(bus.pc_stall_o), 32'd0);
    idle();
    checkOutput("to_after_error", 32'(bus.error_o), 32'd0);
    checkOutput("to_after_stalls", 32'(bus.stall_cycles_o), 32'd0);

    // Counter wrap: 17 redirects on a 4-bit counter.
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    idle();
    checkOutput("wrap_flush_count", 32'(bus.flush_count_o), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 4) < 2,
                    $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the stall and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, including id_stall_i and id_flush_i of the decode stage. It resolves three events in priority order: data-memory wait, taken-branch redirect, load-use hazard. It also keeps a timeout watchdog on memory waits and free-running stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 256, cycles in MEM_WAIT before entering ERROR (minimum 2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
id_rs1_i  in  5  rs1 field of instruction in ID
id_rs2_i  in  5  rs2 field of instruction in ID
ex_rd_i  in  5  rd held in ID/EX register
ex_read_mem_i  in  1  ID/EX instruction is a load
ex_branch_taken_i  in  1  branch/jump resolved taken in EX
dmem_req_i  in  1  MEM stage has an access in flight
dmem_ready_i  in  1  data memory completes access this cycle
pc_stall_o  out  1  hold PC
if_stall_o  out  1  hold IF/ID register
if_flush_o  out  1  zero IF/ID register
id_stall_o  out  1  hold ID/EX register (to decode id_stall_i)
id_flush_o  out  1  zero ID/EX register (to decode id_flush_i)
ex_stall_o  out  1  hold EX/MEM register
mem_stall_o  out  1  hold MEM/WB register
error_o  out  1  sticky memory-timeout error
stall_cycles_o  out  CNT_W  cycles with pc_stall_o=1
flush_count_o  out  CNT_W  taken-branch redirects

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port named reset.
- Reset: state=RUN, watchdog=0, error_o=0, both counters=0. All control outputs are 0 while reset=1.
- Control outputs are combinational from state and current inputs (zero-latency). State and counters update on posedge clk.
- Load-use hazard: ex_read_mem_i & ex_rd_i!=0 & (ex_rd_i==id_rs1_i | ex_rd_i==id_rs2_i). x0 never hazards.
- Memory-wait condition (mw): dmem_req_i & !dmem_ready_i.
- States: RUN, MEM_WAIT, ERROR (2-bit encoding).
- RUN, first match wins:
  - mw: all stalls=1 (pc, if, id, ex, mem). Next state MEM_WAIT, watchdog=1.
  - ex_branch_taken_i: if_flush_o=1, id_flush_o=1, no stalls. Stay RUN; flush_count++. Branch overrides load-use because the ID instruction is wrong-path.
  - Load-use: pc_stall_o=1, if_stall_o=1, id_flush_o=1 (bubble into EX). Stay RUN.
  - Otherwise: all outputs 0.
- MEM_WAIT:
  - dmem_ready_i=1: all stalls=0, flushes=0, next state RUN, watchdog=0. Branch/load-use inputs are re-evaluated next cycle in RUN, not this cycle.
  - dmem_ready_i=0: all stalls=1, watchdog++. When watchdog reaches MEM_TIMEOUT, next state ERROR.
  - ex_branch_taken_i is ignored while in MEM_WAIT (EX is frozen; the input stays held).
- ERROR: all stalls=1, error_o=1. Only reset exits.
- Flushes and stalls on the same register never assert together, except id_flush_o with pc/if stall on load-use. Flush has priority at the register.
- stall_cycles_o increments every cycle pc_stall_o=1, including ERROR. Both counters wrap modulo 2^CNT_W.
- Reset asserted mid-MEM_WAIT: RUN on the next edge, watchdog cleared, counters cleared.

Decomposition:
- definitions.vh: state encodings CTRL_RUN=2'd0, CTRL_MEM_WAIT=2'd1, CTRL_ERROR=2'd2.
- One sub-module, hazard_detect: combinational load-use compare (id_rs1_i, id_rs2_i, ex_rd_i, ex_read_mem_i -> load_use). Reused later by the forwarding unit.
- Target size: FSM, watchdog and counters in roughly 150-200 lines.

Test Plan:
- Load-use: ex_read_mem_i=1, ex_rd_i=5, id_rs1_i=5 -> pc_stall_o=if_stall_o=id_flush_o=1 that cycle, stall_cycles_o=1 after the edge. Same with ex_rd_i=0 -> no stall.
- Branch with hazard: ex_branch_taken_i=1 and load-use both true -> if_flush_o=id_flush_o=1, pc_stall_o=0, flush_count_o=1.
- Memory wait: dmem_req_i=1, dmem_ready_i=0 for 3 cycles then 1 -> all stalls=1 for 3 cycles, 0 on the ready cycle, state returns to RUN, stall_cycles_o=3.
- Branch during wait: ex_branch_taken_i=1 throughout a 2-cycle wait -> no flush during the wait, flush on the first RUN cycle after ready, flush_count_o=1.
- Timeout: MEM_TIMEOUT=4, dmem_ready_i held 0 -> error_o=1 after the 4th wait cycle, all stalls stay 1. reset=1 for one cycle -> error_o=0, counters=0, state RUN.
- Counter wrap: CNT_W=4, 17 redirects -> flush_count_o=1.
